// File: rtl/seg7_frame_decoder.sv
// Receive-side decoder for the 4-digit 7-segment snake animation: glitch filter, glyph decode,
// frame tracker. Define SEG7_DEC_ERRCNT_EN to add the saturating err_cnt output.
module seg7_frame_decoder #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned LOCK_FRAMES   = 3,
  parameter int unsigned LAP_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [0:6]       disp_0,
  input  logic [0:6]       disp_1,
  input  logic [0:6]       disp_2,
  input  logic [0:6]       disp_3,
  output logic [15:0]      digit_val,
  output logic [3:0]       digit_ok,
  output logic [3:0]       blank,
  output logic             frame_strobe,
  output logic             frame_valid,
  output logic [3:0]       frame_idx,
  output logic             locked,
  output logic [LAP_W-1:0] lap_cnt,
  output logic             err
`ifdef SEG7_DEC_ERRCNT_EN
  ,
  output logic [7:0]       err_cnt
`endif
);

  localparam int unsigned CntW  = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned GoodW = $clog2(LOCK_FRAMES + 1);
  localparam logic [CntW-1:0]  CntMax  = CntW'(STABLE_CYCLES);
  localparam logic [GoodW-1:0] GoodMax = GoodW'(LOCK_FRAMES);

  typedef enum logic [1:0] {StHunt, StTrack, StLocked} state_e;

  // Returns {ok, nibble}; segment bit 0 = a, input is active-low.
  function automatic logic [4:0] decode_glyph(input logic [6:0] seg_n);
    logic [4:0] r;
    unique case (~seg_n)
      7'h3F:   r = 5'h10;
      7'h06:   r = 5'h11;
      7'h5B:   r = 5'h12;
      7'h4F:   r = 5'h13;
      7'h66:   r = 5'h14;
      7'h6D:   r = 5'h15;
      7'h7D:   r = 5'h16;
      7'h07:   r = 5'h17;
      7'h7F:   r = 5'h18;
      7'h6F:   r = 5'h19;
      7'h77:   r = 5'h1A;
      7'h7C:   r = 5'h1B;
      7'h39:   r = 5'h1C;
      7'h5E:   r = 5'h1D;
      7'h79:   r = 5'h1E;
      7'h71:   r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  // Bit position is 7*digit + segment of the single lit segment.
  function automatic logic [27:0] frame_pat(input logic [3:0] idx);
    logic [27:0] p;
    logic [4:0]  pos;
    case (idx)
      4'd1:    pos = 5'd7;
      4'd2:    pos = 5'd14;
      4'd3:    pos = 5'd21;
      4'd4:    pos = 5'd22;
      4'd5:    pos = 5'd23;
      4'd6:    pos = 5'd24;
      4'd7:    pos = 5'd17;
      4'd8:    pos = 5'd10;
      4'd9:    pos = 5'd3;
      4'd10:   pos = 5'd4;
      4'd11:   pos = 5'd5;
      default: pos = 5'd0;
    endcase
    p      = '1;
    p[pos] = 1'b0;
    return p;
  endfunction

  function automatic logic [3:0] next_idx(input logic [3:0] x);
    return (x == 4'd11) ? 4'd0 : x + 4'd1;
  endfunction

  logic [27:0]      pins, sample_q, prev_q, last_q;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             changed, accept;
  logic [4:0]       glyph;
  logic [15:0]      dec_val, digit_val_q;
  logic [3:0]       dec_ok, dec_blank, dec_idx, digit_ok_q, blank_q, frame_idx_q;
  logic             dec_valid, frame_valid_q, frame_strobe_q;
  state_e           state_q, state_d;
  logic [3:0]       expected_q, expected_d;
  logic [GoodW-1:0] good_q, good_d;
  logic [LAP_W-1:0] lap_q, lap_d;
  logic             err_q, err_d, locked_q, locked_d;

  always_comb begin
    pins = '0;
    for (int s = 0; s < 7; s++) begin
      pins[s]      = disp_0[s];
      pins[7 + s]  = disp_1[s];
      pins[14 + s] = disp_2[s];
      pins[21 + s] = disp_3[s];
    end
    changed = (sample_q != prev_q);
    if (changed) begin
      cnt_d = CntW'(1);
    end else if (cnt_q == CntMax) begin
      cnt_d = CntMax;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
    // Strobe only on the first arrival at the threshold, and only for a new pattern.
    accept = (cnt_d == CntMax) && (changed || (cnt_q != CntMax)) && (sample_q != last_q);
  end

  always_comb begin
    dec_val   = '0;
    dec_ok    = '0;
    dec_blank = '0;
    dec_valid = 1'b0;
    dec_idx   = '0;
    glyph     = '0;
    for (int d = 0; d < 4; d++) begin
      glyph              = decode_glyph(sample_q[7*d +: 7]);
      dec_ok[d]          = glyph[4];
      dec_val[4*d +: 4]  = glyph[3:0];
      dec_blank[d]       = &sample_q[7*d +: 7];
    end
    for (int f = 0; f < 12; f++) begin
      if (sample_q == frame_pat(4'(f))) begin
        dec_valid = 1'b1;
        dec_idx   = 4'(f);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    good_d     = good_q;
    lap_d      = lap_q;
    err_d      = 1'b0;
    if (accept) begin
      if ((state_q != StHunt) && dec_valid && (dec_idx == expected_q)) begin
        expected_d = next_idx(expected_q);
        if (state_q == StLocked) begin
          if (expected_q == 4'd0) lap_d = lap_q + LAP_W'(1);
        end else begin
          good_d = good_q + GoodW'(1);
          if (good_d == GoodMax) state_d = StLocked;
        end
      end else begin
        err_d = (state_q == StLocked);
        if (dec_valid) begin
          state_d    = StTrack;
          expected_d = next_idx(dec_idx);
          good_d     = GoodW'(1);
        end else begin
          state_d = StHunt;
          good_d  = '0;
        end
      end
    end
    // Hold locked high through the err cycle so it falls one cycle later.
    locked_d = (state_d == StLocked) || err_d;
  end

`ifdef SEG7_DEC_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end
  assign err_cnt = err_cnt_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sample_q       <= '1;
      prev_q         <= '1;
      last_q         <= '1;
      cnt_q          <= '0;
      frame_strobe_q <= 1'b0;
      digit_val_q    <= '0;
      digit_ok_q     <= '0;
      blank_q        <= '0;
      frame_valid_q  <= 1'b0;
      frame_idx_q    <= '0;
      state_q        <= StHunt;
      expected_q     <= '0;
      good_q         <= '0;
      lap_q          <= '0;
      err_q          <= 1'b0;
      locked_q       <= 1'b0;
    end else begin
      sample_q       <= pins;
      prev_q         <= sample_q;
      cnt_q          <= cnt_d;
      frame_strobe_q <= accept;
      if (accept) begin
        last_q        <= sample_q;
        digit_val_q   <= dec_val;
        digit_ok_q    <= dec_ok;
        blank_q       <= dec_blank;
        frame_valid_q <= dec_valid;
        frame_idx_q   <= dec_idx;
      end
      state_q    <= state_d;
      expected_q <= expected_d;
      good_q     <= good_d;
      lap_q      <= lap_d;
      err_q      <= err_d;
      locked_q   <= locked_d;
    end
  end

  assign digit_val    = digit_val_q;
  assign digit_ok     = digit_ok_q;
  assign blank        = blank_q;
  assign frame_strobe = frame_strobe_q;
  assign frame_valid  = frame_valid_q;
  assign frame_idx    = frame_idx_q;
  assign locked       = locked_q;
  assign lap_cnt      = lap_q;
  assign err          = err_q;

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// Bench for seg7_frame_decoder: decode vector table, then animation lock/lap/error/reset sequences.
module tb_seg7_frame_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [0:6]  disp_0 = '1, disp_1 = '1, disp_2 = '1, disp_3 = '1;
  logic [15:0] digit_val;
  logic [3:0]  digit_ok, blank, frame_idx;
  logic        frame_strobe, frame_valid, locked, err;
  logic [7:0]  lap_cnt;
`ifdef SEG7_DEC_ERRCNT_EN
  logic [7:0]  err_cnt;
`endif

  seg7_frame_decoder #(
    .STABLE_CYCLES (4),
    .LOCK_FRAMES   (3),
    .LAP_W         (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .disp_0       (disp_0),
    .disp_1       (disp_1),
    .disp_2       (disp_2),
    .disp_3       (disp_3),
    .digit_val    (digit_val),
    .digit_ok     (digit_ok),
    .blank        (blank),
    .frame_strobe (frame_strobe),
    .frame_valid  (frame_valid),
    .frame_idx    (frame_idx),
    .locked       (locked),
    .lap_cnt      (lap_cnt),
    .err          (err)
`ifdef SEG7_DEC_ERRCNT_EN
    ,
    .err_cnt      (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [27:0] pat;
    logic [15:0] val;
    logic [3:0]  ok;
    logic [3:0]  blk;
    logic        fv;
    logic [3:0]  fi;
  } vec_t;

  vec_t vecs[13];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_stb, n_errp, stb_idx, total_err;
  logic lock_stb, lock_end;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Active-high segment codes (bit0 = a) per digit, inverted to pin level.
  function automatic logic [27:0] mk(input logic [6:0] g3, input logic [6:0] g2,
                                     input logic [6:0] g1, input logic [6:0] g0);
    return ~{g3, g2, g1, g0};
  endfunction

  function automatic logic [27:0] fpat(input int idx);
    int fdig[12] = '{0, 1, 2, 3, 3, 3, 3, 2, 1, 0, 0, 0};
    int fseg[12] = '{0, 0, 0, 0, 1, 2, 3, 3, 3, 3, 4, 5};
    logic [27:0] p;
    p = '1;
    p[7*fdig[idx] + fseg[idx]] = 1'b0;
    return p;
  endfunction

  task automatic drive(input logic [27:0] p);
    for (int s = 0; s < 7; s++) begin
      disp_0[s] = p[s];
      disp_1[s] = p[7 + s];
      disp_2[s] = p[14 + s];
      disp_3[s] = p[21 + s];
    end
  endtask

  task automatic wait_strobe(output int lat, output bit seen);
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (frame_strobe) seen = 1'b1;
    end
  endtask

  task automatic play(input int idx, input int hold);
    drive(fpat(idx));
    n_stb    = 0;
    n_errp   = 0;
    stb_idx  = 15;
    lock_stb = 1'b0;
    repeat (hold) begin
      @(posedge clk);
      #1;
      if (frame_strobe) begin
        n_stb++;
        stb_idx  = int'(frame_idx);
        lock_stb = locked;
      end
      if (err) n_errp++;
    end
    lock_end  = locked;
    total_err += n_errp;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " digit_val"}, 32'(digit_val), 0);
    check({tag, " digit_ok"}, 32'(digit_ok), 0);
    check({tag, " blank"}, 32'(blank), 0);
    check({tag, " strobe"}, 32'(frame_strobe), 0);
    check({tag, " valid"}, 32'(frame_valid), 0);
    check({tag, " idx"}, 32'(frame_idx), 0);
    check({tag, " locked"}, 32'(locked), 0);
    check({tag, " lap"}, 32'(lap_cnt), 0);
    check({tag, " err"}, 32'(err), 0);
  endtask

  initial begin
    int lat;
    bit seen;
    int cnt;

    vecs[0]  = '{mk(7'h66, 7'h4F, 7'h5B, 7'h06), 16'h4321, 4'hF, 4'h0, 1'b0, 4'd0};
    vecs[1]  = '{mk(7'h7F, 7'h07, 7'h7D, 7'h6D), 16'h8765, 4'hF, 4'h0, 1'b0, 4'd0};
    vecs[2]  = '{mk(7'h39, 7'h7C, 7'h77, 7'h6F), 16'hCBA9, 4'hF, 4'h0, 1'b0, 4'd0};
    vecs[3]  = '{mk(7'h3F, 7'h71, 7'h79, 7'h5E), 16'h0FED, 4'hF, 4'h0, 1'b0, 4'd0};
    vecs[4]  = '{mk(7'h7F, 7'h01, 7'h00, 7'h06), 16'h8001, 4'b1001, 4'b0010, 1'b0, 4'd0};
    vecs[5]  = '{mk(7'h00, 7'h00, 7'h00, 7'h01), 16'h0000, 4'h0, 4'b1110, 1'b1, 4'd0};
    vecs[6]  = '{mk(7'h04, 7'h00, 7'h00, 7'h00), 16'h0000, 4'h0, 4'b0111, 1'b1, 4'd5};
    vecs[7]  = '{mk(7'h00, 7'h08, 7'h00, 7'h00), 16'h0000, 4'h0, 4'b1011, 1'b1, 4'd7};
    vecs[8]  = '{mk(7'h00, 7'h00, 7'h00, 7'h20), 16'h0000, 4'h0, 4'b1110, 1'b1, 4'd11};
    vecs[9]  = '{mk(7'h00, 7'h00, 7'h00, 7'h10), 16'h0000, 4'h0, 4'b1110, 1'b1, 4'd10};
    vecs[10] = '{mk(7'h00, 7'h00, 7'h00, 7'h03), 16'h0000, 4'h0, 4'b1110, 1'b0, 4'd0};
    vecs[11] = '{mk(7'h00, 7'h00, 7'h00, 7'h08), 16'h0000, 4'h0, 4'b1110, 1'b1, 4'd9};
    vecs[12] = '{mk(7'h02, 7'h00, 7'h00, 7'h00), 16'h0000, 4'h0, 4'b0111, 1'b1, 4'd4};

    // Reset and idle on all-blank.
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (frame_strobe) cnt++;
    end
    check("blank no strobe", 32'(cnt), 0);
    check_all_zero("blank idle");

    // Decode table.
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].pat);
      wait_strobe(lat, seen);
      check($sformatf("v%0d strobe", i), 32'(seen), 1);
      check($sformatf("v%0d latency", i), 32'(lat), 5);
      check($sformatf("v%0d digit_val", i), 32'(digit_val), 32'(vecs[i].val));
      check($sformatf("v%0d digit_ok", i), 32'(digit_ok), 32'(vecs[i].ok));
      check($sformatf("v%0d blank", i), 32'(blank), 32'(vecs[i].blk));
      check($sformatf("v%0d frame_valid", i), 32'(frame_valid), 32'(vecs[i].fv));
      check($sformatf("v%0d frame_idx", i), 32'(frame_idx), 32'(vecs[i].fi));
      cnt = 0;
      repeat (5) begin
        @(posedge clk);
        #1;
        if (frame_strobe) cnt++;
      end
      check($sformatf("v%0d held no restrobe", i), 32'(cnt), 0);
    end

    // Animation: lock on frame 2, lap on 11->0.
    drive('1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    total_err = 0;
    play(0, 8);
    check("f0 strobe", 32'(n_stb), 1);
    check("f0 idx", 32'(stb_idx), 0);
    check("f0 unlocked", 32'(lock_end), 0);
    play(1, 8);
    check("f1 unlocked", 32'(lock_end), 0);
    play(2, 8);
    check("f2 lock at strobe", 32'(lock_stb), 1);
    for (int f = 3; f < 12; f++) begin
      play(f, 8);
      check($sformatf("f%0d strobe idx", f), 32'(stb_idx), 32'(f));
    end
    check("pre-wrap lap", 32'(lap_cnt), 0);
    play(0, 8);
    check("wrap lap", 32'(lap_cnt), 1);
    check("wrap locked", 32'(locked), 1);
    check("run no err", 32'(total_err), 0);

    // Glitch between 4 and 5 must be filtered.
    for (int f = 1; f < 5; f++) play(f, 8);
    drive(fpat(7));
    cnt = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (frame_strobe) cnt++;
    end
    play(5, 8);
    check("glitch strobes", 32'(cnt + n_stb), 1);
    check("glitch idx", 32'(stb_idx), 5);
    check("glitch locked", 32'(lock_end), 1);
    check("glitch no err", 32'(n_errp), 0);

    // Out-of-order frame while locked.
    play(8, 8);
    check("break err pulses", 32'(n_errp), 1);
    check("break unlocked", 32'(lock_end), 0);
`ifdef SEG7_DEC_ERRCNT_EN
    check("break err_cnt", 32'(err_cnt), 1);
`endif
    play(9, 8);
    check("relock f9 unlocked", 32'(lock_end), 0);
    play(10, 8);
    check("relock f10 locked", 32'(lock_end), 1);
    check("relock lap kept", 32'(lap_cnt), 1);
    play(11, 8);
    play(0, 8);
    check("lap two", 32'(lap_cnt), 2);
    for (int f = 1; f < 12; f++) play(f, 8);
    play(0, 8);
    check("lap three", 32'(lap_cnt), 3);
    check("lap three locked", 32'(locked), 1);

    // One-cycle reset while locked.
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_all_zero("midreset");
    wait_strobe(lat, seen);
    check("post-reset strobe", 32'(seen), 1);
    check("post-reset valid", 32'(frame_valid), 1);
    check("post-reset idx", 32'(frame_idx), 0);
    check("post-reset unlocked", 32'(locked), 0);
    play(1, 8);
    check("post-reset f1 unlocked", 32'(lock_end), 0);
    play(2, 8);
    check("post-reset f2 lock", 32'(lock_stb), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seg7_frame_decoder.md
Name: seg7_frame_decoder

Overview:
- Receive-side counterpart of the 4-digit 7-segment animation driver: samples the four active-low display buses, filters glitches, and decodes each digit back to a hex nibble.
- Recognises the 12-frame "snake" animation, tracks the frame index, and declares lock after a run of correct successive frames.
- Sits on the board-test/self-check path, either snooping the display pins or fed from a display generator in simulation.

Parameters:
- STABLE_CYCLES, 4: consecutive identical samples required before a display pattern is accepted (min 1).
- LOCK_FRAMES, 3: consecutive in-order animation frames required to enter LOCKED (min 2).
- LAP_W, 8: width of the lap counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- disp_0  in  [0:6]  digit 0 segments, index 0=a … 6=g, 0 = lit
- disp_1  in  [0:6]  digit 1, same encoding
- disp_2  in  [0:6]  digit 2
- disp_3  in  [0:6]  digit 3
- digit_val  out  16  decoded nibbles, [3:0]=disp_0 … [15:12]=disp_3
- digit_ok  out  4  bit n = disp_n matches a hex glyph 0-F
- blank  out  4  bit n = disp_n is 7'b1111111
- frame_strobe  out  1  one-cycle pulse when a new pattern is accepted
- frame_valid  out  1  accepted pattern is one of the 12 animation frames
- frame_idx  out  4  index 0..11 of that frame (0 if not valid)
- locked  out  1  animation tracker in LOCKED
- lap_cnt  out  LAP_W  completed 11→0 wraps while LOCKED
- err  out  1  one-cycle pulse on a sequence break while LOCKED

Behaviour:
- Reset (rst_n=0 at a clk edge): all outputs 0; stability counter 0; last-accepted pattern = all 28 bits 1 (all blank); tracker HUNT. Reset mid-operation discards a partial filter count and the lock immediately.
- Input stage:
  - The 28-bit concatation {disp_3,disp_2,disp_1,disp_0} is registered every cycle.
  - Counter increments while the registered sample equals the previous sample and saturates at STABLE_CYCLES; any change reloads it to 1.
- Accept: frame_strobe pulses in the cycle the counter first reaches STABLE_CYCLES, but only if the sample differs from last-accepted. An unchanged held pattern never re-strobes. Pin-change to strobe latency = STABLE_CYCLES+1 cycles.
- Decode outputs (digit_val, digit_ok, blank, frame_valid, frame_idx) update in the same cycle as frame_strobe and hold until the next strobe.
- Glyph decode: standard active-high patterns, inverted. 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71 (hex with bit0=a). A non-matching digit gives digit_ok=0 and nibble 0.
- Frame table: exactly one segment lit on exactly one digit, all other digits blank.
  - 0-3: seg a on disp_0, disp_1, disp_2, disp_3
  - 4: b on disp_3
  - 5: c on disp_3
  - 6: d on disp_3
  - 7: d on disp_2
  - 8: d on disp_1
  - 9: d on disp_0
  - 10: e on disp_0
  - 11: f on disp_0
- Tracker FSM, evaluated only on frame_strobe:
  - HUNT: valid frame → TRACK with expected=(idx+1) mod 12, good=1; otherwise stay.
  - TRACK: idx==expected → good++, expected advances; good==LOCK_FRAMES → LOCKED. Mismatch or invalid frame → reseed as in HUNT (valid frame) or go to HUNT (invalid).
  - LOCKED: idx==expected → stay and advance expected; a transition 11→0 increments lap_cnt (wraps mod 2^LAP_W). Mismatch → err pulse same cycle, locked drops next cycle, reseed/HUNT as in TRACK.
- lap_cnt holds its value when lock is lost; only reset clears it.

Optional Feature:
- Macro SEG7_DEC_ERRCNT_EN.
- Defined: extra output err_cnt[7:0] counts err pulses, saturates at 255, cleared by reset; also counts invalid-pattern accepts while LOCKED.
- Undefined: port absent; err behaviour unchanged.

Test Plan:
- Reset, then drive all-blank for 20 cycles → frame_strobe never pulses; all outputs 0, locked=0.
- Drive "1234" glyphs (disp_0=~06 … disp_3=~66) held 10 cycles → single strobe 5 cycles after change; digit_val=0x4321, digit_ok=4'hF, frame_valid=0.
- Play frames 0..11 then 0 at 8 cycles each → locked rises at the strobe after frame 2 (LOCK_FRAMES=3); lap_cnt=1 after the frame-0 wrap; err never pulses.
- While LOCKED at frame 5, inject frame 8 → err pulses once, locked=0, tracker reseeded expecting 9; frames 9,10 relock.
- 2-cycle glitch to frame 7 between frames 4 and 5 → no strobe for the glitch; lock held.
- Assert rst_n=0 for one cycle while LOCKED with lap_cnt=3 → all outputs 0 next cycle; the next valid frame starts TRACK.
